// File: rtl/road_merge_pkg.sv
// Shared types and helpers for the road stream merger.
package road_merge_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        MARK  = 2'd2
    } merge_state_t;

    localparam int TS_W = 16;

    // Channel-index width; never narrower than one bit.
    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/road_fifo.sv
// Single-clock FIFO with full/empty flags and show-ahead read data.
// Latency: a word written at edge t is readable after edge t.
// Backpressure: none internally; the caller must not write when full (unless reading) nor read when empty.
module road_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/road_stream_merger.sv
// Merges N_CH road-word channels round-robin onto one stream, then an end-of-run count marker (ROAD_MERGE_TS_EN adds out_ts).
// Latency: a word written at edge t appears on the output after edge t+1 at the earliest.
// Backpressure: out_rdy stalls the output register; sources are never stalled, a full FIFO drops and sets ovf.
module road_stream_merger
    import road_merge_pkg::*;
#(
    parameter int  N_CH       = 4,
    parameter int  DATA_W     = 30,
    parameter int  FIFO_DEPTH = 16,
    parameter int  CNT_W      = 32,
    localparam int CH_W       = ch_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_dv,
    input  logic                   eor,
    output logic [DATA_W-1:0]      out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_dv,
    input  logic                   out_rdy,
    output logic                   out_eor,
    output logic [N_CH-1:0]        ovf,
    output logic                   busy
`ifdef ROAD_MERGE_TS_EN
    ,
    output logic [TS_W-1:0]        out_ts
`endif
);
`ifdef ROAD_MERGE_TS_EN
    localparam int FW = DATA_W + TS_W;
`else
    localparam int FW = DATA_W;
`endif
    // Counter bits above DATA_W never reach the marker, so they are not stored.
    localparam int CNT_KEEP = (CNT_W < DATA_W) ? CNT_W : DATA_W;

    merge_state_t        state, state_nxt;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     gnt_ch;
    logic [CH_W-1:0]     idx;
    logic                gnt_vld, grant, xfer, mark_xfer, load_mark, capture;
    logic [N_CH-1:0]     fifo_full, fifo_empty, fifo_wr, fifo_rd, ovf_set;
    logic [FW-1:0]       fifo_wr_dat [N_CH];
    logic [FW-1:0]       fifo_rd_dat [N_CH];
    logic [FW-1:0]       sel_dat;
    logic [CNT_KEEP-1:0] word_cnt;

`ifdef ROAD_MERGE_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 1'b1;
    end
`endif

    assign capture   = (state == RUN);
    assign xfer      = out_dv && out_rdy;
    assign mark_xfer = xfer && out_eor;
    assign load_mark = (state == DRAIN) && (&fifo_empty) && !out_dv;
    assign busy      = (state != RUN);
    assign grant     = gnt_vld && (state != MARK) && (!out_dv || out_rdy);
    assign sel_dat   = fifo_rd_dat[gnt_ch];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
`ifdef ROAD_MERGE_TS_EN
        assign fifo_wr_dat[c] = {ts_cnt, in_data[c*DATA_W +: DATA_W]};
`else
        assign fifo_wr_dat[c] = in_data[c*DATA_W +: DATA_W];
`endif
        // A full FIFO being read this cycle still has room for the incoming word.
        assign fifo_rd[c] = grant && (gnt_ch == CH_W'(c));
        assign fifo_wr[c] = capture && in_dv[c] && (!fifo_full[c] || fifo_rd[c]);
        assign ovf_set[c] = capture && in_dv[c] && fifo_full[c] && !fifo_rd[c];

        road_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (fifo_wr[c]),
            .wr_dat (fifo_wr_dat[c]),
            .rd_en  (fifo_rd[c]),
            .rd_dat (fifo_rd_dat[c]),
            .full   (fifo_full[c]),
            .empty  (fifo_empty[c])
        );
    end

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = CH_W'((int'(rr_ptr) + i) % N_CH);
            if (!gnt_vld && !fifo_empty[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_dv   <= 1'b0;
            out_eor  <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
        end else if (grant) begin
            out_dv   <= 1'b1;
            out_eor  <= 1'b0;
            out_ch   <= gnt_ch;
            out_data <= sel_dat[DATA_W-1:0];
        end else if (load_mark) begin
            out_dv   <= 1'b1;
            out_eor  <= 1'b1;
            out_ch   <= '0;
            out_data <= DATA_W'(word_cnt);
        end else if (xfer) begin
            out_dv   <= 1'b0;
            out_eor  <= 1'b0;
        end
    end

`ifdef ROAD_MERGE_TS_EN
    always_ff @(posedge clk) begin
        if (rst)            out_ts <= '0;
        else if (grant)     out_ts <= sel_dat[FW-1 -: TS_W];
        else if (load_mark) out_ts <= ts_cnt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || mark_xfer) begin
            word_cnt <= '0;
            rr_ptr   <= '0;
            ovf      <= '0;
        end else begin
            if (xfer)  word_cnt <= word_cnt + 1'b1;
            if (grant) rr_ptr   <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
            ovf <= ovf | ovf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (eor)       state_nxt = DRAIN;
            DRAIN:   if (load_mark) state_nxt = MARK;
            MARK:    if (mark_xfer) state_nxt = RUN;
            default:                state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_road_stream_merger.sv
// Directed bench for road_stream_merger with an ordered expected-output scoreboard.
module tb_road_stream_merger;
    localparam int N_CH   = 4;
    localparam int DATA_W = 30;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic              eor;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] dat;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst, eor, out_rdy, out_dv, out_eor, busy;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_dv, ovf;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic [N_CH*DATA_W-1:0] d;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   run_words   = 0;

    always #5 clk = ~clk;

    road_stream_merger #(.N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(16), .CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_dv    (in_dv),
        .eor      (eor),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_dv   (out_dv),
        .out_rdy  (out_rdy),
        .out_eor  (out_eor),
        .ovf      (ovf),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [N_CH-1:0] dv, input logic [N_CH*DATA_W-1:0] dat);
        in_dv   = dv;
        in_data = dat;
        step();
        in_dv   = '0;
    endtask

    function automatic logic [N_CH*DATA_W-1:0] lane(input int c, input logic [DATA_W-1:0] v);
        logic [N_CH*DATA_W-1:0] r;
        r = '0;
        r[c*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    task automatic push(input int c, input logic [DATA_W-1:0] v);
        exp_t x;
        x.eor = 1'b0;
        x.ch  = CH_W'(c);
        x.dat = v;
        exp_q.push_back(x);
        run_words++;
    endtask

    task automatic push_mark();
        exp_t x;
        x.eor = 1'b1;
        x.ch  = '0;
        x.dat = DATA_W'(run_words);
        exp_q.push_back(x);
        run_words = 0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        step();
        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL %s_drain observed=%0d pending expected=0 pending", tag, exp_q.size());
        end
    endtask

    // Output monitor: a transfer is due at the next rising edge when out_dv && out_rdy here.
    logic              hold_prev = 1'b0;
    logic [DATA_W-1:0] hold_dat;
    logic [CH_W-1:0]   hold_ch;
    logic              hold_eor;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_dv", 64'(out_dv), 64'd1);
                chk("hold_fields", 64'({out_eor, out_ch, out_data}), 64'({hold_eor, hold_ch, hold_dat}));
            end
            if (out_dv && out_rdy) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_out observed=ch%0d/%0h/eor%0b expected=nothing", out_ch, out_data, out_eor);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("out_eor", 64'(out_eor), 64'(mon_e.eor));
                    chk("out_ch", 64'(out_ch), 64'(mon_e.ch));
                    chk("out_data", 64'(out_data), 64'(mon_e.dat));
                end
            end
            hold_prev = out_dv && !out_rdy;
            hold_dat  = out_data;
            hold_ch   = out_ch;
            hold_eor  = out_eor;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; eor = 1'b0; out_rdy = 1'b0; in_dv = '0; in_data = '0;
        repeat (2) step();
        chk("rst_out_dv", 64'(out_dv), 64'd0);
        chk("rst_out_eor", 64'(out_eor), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Fairness: all channels, three words each, same cycles.
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = '0;
            for (int c = 0; c < N_CH; c++) begin
                d[c*DATA_W +: DATA_W] = DATA_W'(32'h0050_0000 + c * 256 + k);
                push(c, DATA_W'(32'h0050_0000 + c * 256 + k));
            end
            put(4'hF, d);
        end
        wait_drain("fair");

        // Single word latency on ch2.
        push(2, 30'h1234567);
        put(4'b0100, lane(2, 30'h1234567));
        chk("lat_early_dv", 64'(out_dv), 64'd0);
        step();
        chk("lat_dv", 64'(out_dv), 64'd1);
        chk("lat_ch", 64'(out_ch), 64'd2);
        chk("lat_data", 64'(out_data), 64'h1234567);
        chk("lat_eor", 64'(out_eor), 64'd0);
        wait_drain("single");

        // Overflow: ch0 word occupies the output register, ch1 gets 20 words.
        out_rdy = 1'b0;
        push(0, 30'h0AAAAAA);
        put(4'b0001, lane(0, 30'h0AAAAAA));
        for (int i = 0; i < 20; i++) begin
            if (i < 16) push(1, DATA_W'(32'h000B_0000 + i));
            put(4'b0010, lane(1, DATA_W'(32'h000B_0000 + i)));
        end
        chk("ovf_flag", 64'(ovf), 64'h2);
        chk("ovf_busy", 64'(busy), 64'd0);
        out_rdy = 1'b1;
        wait_drain("ovf");
        chk("ovf_sticky", 64'(ovf), 64'h2);

        // Backpressure: out_rdy toggles every cycle during a 10-word burst.
        for (int i = 0; i < 10; i++) begin
            out_rdy = (i % 2) == 1;
            push(3, DATA_W'(32'h000C_0000 + i));
            put(4'b1000, lane(3, DATA_W'(32'h000C_0000 + i)));
        end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            out_rdy = ~out_rdy;
            step();
        end
        out_rdy = 1'b1;
        wait_drain("bp");

        // Close the first run: marker counts every data word since reset.
        push_mark();
        eor = 1'b1; step(); eor = 1'b0;
        wait_drain("eor1");
        chk("eor1_ovf_clr", 64'(ovf), 64'd0);
        chk("eor1_busy", 64'(busy), 64'd0);

        // Second run: 7 words, eor; inputs and a second eor during DRAIN are ignored.
        out_rdy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push(0, DATA_W'(32'h000D_0000 + i));
            put(4'b0001, lane(0, DATA_W'(32'h000D_0000 + i)));
        end
        push_mark();
        eor = 1'b1; step(); eor = 1'b0;
        chk("eor2_busy", 64'(busy), 64'd1);
        chk("eor2_dv", 64'(out_dv), 64'd1);
        chk("eor2_not_mark", 64'(out_eor), 64'd0);
        eor = 1'b1;
        put(4'b0010, lane(1, 30'h3FFFFFFF));
        eor = 1'b0;
        chk("drain_no_ovf", 64'(ovf), 64'd0);
        out_rdy = 1'b1;
        wait_drain("eor2");
        chk("eor2_ovf_clr", 64'(ovf), 64'd0);
        chk("eor2_busy_done", 64'(busy), 64'd0);

        // Third run is empty: marker restarts from zero.
        push_mark();
        eor = 1'b1; step(); eor = 1'b0;
        wait_drain("eor3");

        // Reset in the middle of DRAIN discards everything.
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) put(4'b0100, lane(2, DATA_W'(32'h000E_0000 + i)));
        eor = 1'b1; step(); eor = 1'b0;
        chk("rstdrain_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        run_words = 0;
        step();
        rst = 1'b0;
        chk("rstdrain_dv", 64'(out_dv), 64'd0);
        chk("rstdrain_eor", 64'(out_eor), 64'd0);
        chk("rstdrain_data", 64'(out_data), 64'd0);
        chk("rstdrain_ch", 64'(out_ch), 64'd0);
        chk("rstdrain_ovf", 64'(ovf), 64'd0);
        chk("rstdrain_state", 64'(busy), 64'd0);
        out_rdy = 1'b1;
        repeat (20) step();
        push(2, 30'h2ABCDEF);
        put(4'b0100, lane(2, 30'h2ABCDEF));
        wait_drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
